// File: rtl/fc_pkg.sv
// Shared state encoding and elaboration-time helpers for the FC layer controller.
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } fc_state_t;

  // Bits needed to hold value-1; never below 1 so degenerate params still give legal vectors.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fc_layer_controller.sv
// Sequences one FC layer: clear PEs, stream in_len element reads, drain PE pipeline, pulse done.
// Latency: in_len + PE_LATENCY + 3 cycles from accepted start to done with no stalls.
// Backpressure: feed_stall holds the read index and suppresses rd_en; start is ignored while busy.
module fc_layer_controller
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int PARALLEL_FC_PE = 32,
  parameter int MAX_IN_LEN     = 1024,
  parameter int PE_LATENCY     = 4,
  localparam int AW            = clog2(MAX_IN_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] in_len,
  input  logic          feed_stall,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          pe_clear,
  output logic          start_FC,
  output logic          busy,
  output logic          done
);

  localparam int DW = clog2(PE_LATENCY + 1);

  if (DATA_WIDTH < 1 || PARALLEL_FC_PE < 1 || MAX_IN_LEN < 1 || PE_LATENCY < 0) begin : g_bad_params
    $error("fc_layer_controller: invalid parameter set");
  end

  fc_state_t     state;
  fc_state_t     state_nxt;
  logic [AW-1:0] len_q;
  logic [AW-1:0] idx_q;
  logic [DW-1:0] drain_cnt;
  logic          last_idx;

  assign last_idx = (idx_q == len_q - AW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pe_clear  = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        pe_clear  = 1'b1;
        state_nxt = (len_q == '0) ? DRAIN : FETCH;
      end
      FETCH: begin
        if (!feed_stall) begin
          rd_en   = 1'b1;
          rd_addr = idx_q;
          if (last_idx) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Counting from entry covers the final start_FC plus the PE pipeline.
        if (drain_cnt == DW'(PE_LATENCY)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      idx_q     <= '0;
      drain_cnt <= '0;
      start_FC  <= 1'b0;
    end else begin
      // Read data returns one cycle after rd_en, so the accumulate enable trails it by one.
      start_FC <= rd_en;
      if (state == IDLE && start) begin
        len_q <= (in_len > AW'(MAX_IN_LEN)) ? AW'(MAX_IN_LEN) : in_len;
      end
      if (state == CLEAR) begin
        idx_q <= '0;
      end else if (rd_en) begin
        idx_q <= idx_q + AW'(1);
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DW'(1);
      end else begin
        drain_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_controller.sv
// Directed bench for fc_layer_controller with small MAX_IN_LEN so the saturation case stays short.
module tb_fc_layer_controller;

  localparam int MAXL = 8;
  localparam int PEL  = 4;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] in_len;
  logic          feed_stall;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          pe_clear;
  logic          start_FC;
  logic          busy;
  logic          done;

  fc_layer_controller #(
    .DATA_WIDTH    (16),
    .PARALLEL_FC_PE(4),
    .MAX_IN_LEN    (MAXL),
    .PE_LATENCY    (PEL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_len    (in_len),
    .feed_stall(feed_stall),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .pe_clear  (pe_clear),
    .start_FC  (start_FC),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-run event log, cycle numbers relative to the start cycle (cycle 0).
  bit mon = 1'b0;
  int t0;
  int mk;
  int n_clr, clr_cyc, n_sfc, sfc_first, sfc_last, n_done, done_cyc, n_busy;
  int addr_q[$];
  int rdcyc_q[$];

  always @(negedge clk) begin
    if (mon) begin
      mk = cyc - t0;
      if (pe_clear) begin n_clr++; clr_cyc = mk; end
      if (rd_en) begin addr_q.push_back(int'(rd_addr)); rdcyc_q.push_back(mk); end
      if (start_FC) begin
        n_sfc++;
        if (n_sfc == 1) sfc_first = mk;
        sfc_last = mk;
      end
      if (done) begin n_done++; done_cyc = mk; end
      if (busy) n_busy++;
    end
  end

  task automatic run(input int len, input int stall_at, input int sa, input int sb,
                     input int rst_at, input int ncyc);
    n_clr = 0; clr_cyc = -1; n_sfc = 0; sfc_first = -1; sfc_last = -1;
    n_done = 0; done_cyc = -1; n_busy = 0;
    addr_q.delete(); rdcyc_q.delete();
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin t0 = cyc; mon = 1'b1; end
      start      = (k == 0) || (k == sa) || (k == sb);
      feed_stall = (k == stall_at);
      in_len     = AW'(len);
      reset      = (k == rst_at);
      if (k == rst_at) begin
        #1;
        check_val("abort_rd_en", int'(rd_en), 0);
        check_val("abort_pe_clear", int'(pe_clear), 0);
        check_val("abort_start_FC", int'(start_FC), 0);
        check_val("abort_busy", int'(busy), 0);
      end
    end
    @(posedge clk); #1;
    mon = 1'b0; start = 1'b0; feed_stall = 1'b0; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_len = '0; feed_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rd_en", int'(rd_en), 0);
    check_val("rst_rd_addr", int'(rd_addr), 0);
    check_val("rst_pe_clear", int'(pe_clear), 0);
    check_val("rst_start_FC", int'(start_FC), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // len 3, no stall
    run(3, -1, -1, -1, -1, 14);
    check_val("l3_clr_n", n_clr, 1);
    check_val("l3_clr_cyc", clr_cyc, 1);
    check_val("l3_rd_n", addr_q.size(), 3);
    for (int i = 0; i < 3 && i < addr_q.size(); i++) begin
      check_val($sformatf("l3_addr%0d", i), addr_q[i], i);
      check_val($sformatf("l3_rdcyc%0d", i), rdcyc_q[i], 2 + i);
    end
    check_val("l3_sfc_n", n_sfc, 3);
    check_val("l3_sfc_first", sfc_first, 3);
    check_val("l3_sfc_last", sfc_last, 5);
    check_val("l3_done_n", n_done, 1);
    check_val("l3_done_cyc", done_cyc, 3 + PEL + 3);
    check_val("l3_busy_cycles", n_busy, 10);

    // len 4, stall on second FETCH cycle
    run(4, 3, -1, -1, -1, 16);
    check_val("st_rd_n", addr_q.size(), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      check_val($sformatf("st_addr%0d", i), addr_q[i], i);
    end
    if (rdcyc_q.size() > 1) check_val("st_rdcyc1", rdcyc_q[1], 4);
    check_val("st_sfc_n", n_sfc, 4);
    check_val("st_done_cyc", done_cyc, 4 + PEL + 3 + 1);

    // len 0
    run(0, -1, -1, -1, -1, 10);
    check_val("z_clr_n", n_clr, 1);
    check_val("z_rd_n", addr_q.size(), 0);
    check_val("z_sfc_n", n_sfc, 0);
    check_val("z_done_cyc", done_cyc, 7);

    // start re-pulsed while busy and in the DONE cycle
    run(3, -1, 3, 10, -1, 20);
    check_val("rs_done_n", n_done, 1);
    check_val("rs_done_cyc", done_cyc, 10);
    check_val("rs_clr_n", n_clr, 1);
    check_val("rs_sfc_n", n_sfc, 3);

    // reset asserted while rd_addr=2 is presented
    run(5, -1, -1, -1, 4, 15);
    check_val("ab_done_n", n_done, 0);
    check_val("ab_rd_n", addr_q.size(), 2);
    run(2, -1, -1, -1, -1, 12);
    check_val("ab2_sfc_n", n_sfc, 2);
    check_val("ab2_done_cyc", done_cyc, 2 + PEL + 3);

    // length above MAX_IN_LEN saturates
    run(MAXL + 5, -1, -1, -1, -1, 20);
    check_val("sat_sfc_n", n_sfc, MAXL);
    check_val("sat_last_addr", (addr_q.size() > 0) ? addr_q[addr_q.size()-1] : -1, MAXL - 1);
    check_val("sat_done_cyc", done_cyc, MAXL + PEL + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_layer_controller.md
FC_LAYER_CONTROLLER -- requirements
Module: fc_layer_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of input and weight elements.
REQ-002 SHALL have parameter PARALLEL_FC_PE, default 32, number of PE columns driven.
REQ-003 SHALL have parameter MAX_IN_LEN, default 1024, maximum input-vector length.
REQ-004 SHALL have parameter PE_LATENCY, default 4, cycles from the last accumulate-enabled cycle to a stable PE output.
REQ-005 SHALL define localparam AW = clog2(MAX_IN_LEN+1).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: layer-start request.
REQ-009 SHALL have port in_len, input, AW bits: input elements to process; sampled on accepted start.
REQ-010 SHALL have port feed_stall, input, 1 bit: input/weight memory not ready this cycle.
REQ-011 SHALL have port rd_en, output, 1 bit: read strobe to input memory and weight cache.
REQ-012 SHALL have port rd_addr, output, AW bits: element index read (input word and weight row share the index).
REQ-013 SHALL have port pe_clear, output, 1 bit: clears all PE accumulators.
REQ-014 SHALL have port start_FC, output, 1 bit: PE accumulate enable, aligned with returned data.
REQ-015 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse; output_fc valid.

Function
REQ-017 SHALL implement states IDLE, CLEAR, FETCH, DRAIN, DONE.
REQ-018 IDLE: on start=1 latch in_len and go to CLEAR; otherwise remain.
REQ-019 CLEAR: pe_clear=1 for exactly one cycle, then go to FETCH, or to DRAIN if the latched length is 0.
REQ-020 FETCH: each cycle with feed_stall=0, rd_en=1 and rd_addr=current index, then increment the index; when feed_stall=1, rd_en=0 and the index holds.
REQ-021 Memory read latency is fixed at one cycle; start_FC SHALL equal rd_en delayed one cycle (registered).
REQ-022 After issuing index len-1, SHALL go to DRAIN; rd_addr never exceeds len-1.
REQ-023 DRAIN: SHALL wait 1+PE_LATENCY cycles counted from entry (covers the final start_FC), then go to DONE.
REQ-024 DONE: done=1 for one cycle, then return to IDLE; busy=0 from the next cycle.
REQ-025 start while busy=1 SHALL be ignored; no queuing.
REQ-026 A start in the same cycle that DONE returns to IDLE SHALL be ignored; acceptance occurs only while in IDLE.
REQ-027 in_len > MAX_IN_LEN SHALL be saturated to MAX_IN_LEN.
REQ-028 feed_stall SHALL be ignored outside FETCH.
REQ-029 Total cycles from accepted start to done, with no stalls, SHALL be len+PE_LATENCY+3.

Reset
REQ-030 On reset=1, asynchronously: state=IDLE; index, length and drain counters=0; rd_en, rd_addr, pe_clear, start_FC, busy and done=0.
REQ-031 Reset mid-operation SHALL abort with no done pulse; the first start after reset deassertion SHALL begin a fresh layer.

Structure
REQ-032 State encoding and the clog2 helper SHALL reside in shared package fc_pkg.
REQ-033 SHALL contain no sub-module; one FSM plus index and drain counters, designed to sit beside FC_Layer_ANN.

Verification
REQ-034 reset; start with in_len=3, no stall -> pe_clear at cycle 1; rd_addr 0,1,2 at cycles 2-4; start_FC at cycles 3-5; done at cycle 10 (PE_LATENCY=4).
REQ-035 in_len=4 with feed_stall=1 on the second FETCH cycle -> rd_addr sequence 0,(hold),1,2,3; exactly 4 start_FC pulses; done delayed by 1 cycle.
REQ-036 in_len=0 -> pe_clear pulse, zero rd_en/start_FC pulses, done 7 cycles after start.
REQ-037 start re-pulsed while busy and at the DONE cycle -> ignored; exactly one done pulse.
REQ-038 reset asserted during FETCH at index 2 -> all outputs 0 immediately, no done; a new start with in_len=2 completes normally.
REQ-039 in_len=MAX_IN_LEN+5 -> exactly MAX_IN_LEN start_FC pulses; last rd_addr = MAX_IN_LEN-1.
